// File: rtl/counter_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : counter_step_scheduler
// Description : Round-robin burst scheduler for the counter datapath; paces
//               grants into prescaled one-cycle steps and mirrors the count.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_step_scheduler #(
    parameter int WIDTH = 3,
    parameter int MOD_N = 6,
    parameter int LEN_W = 4,
    parameter int DIV   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             clear,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             step,
    output logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy
);

    localparam logic [1:0]       c_stIdle   = 2'd0;
    localparam logic [1:0]       c_stRun    = 2'd1;
    localparam logic [1:0]       c_stDone   = 2'd2;
    localparam logic [7:0]       c_divLast  = 8'(DIV - 1);
    localparam logic [WIDTH-1:0] c_countMax = WIDTH'(MOD_N - 1);
    localparam logic [LEN_W-1:0] c_lenOne   = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       r_gnt;
    logic             r_last;
    logic [LEN_W-1:0] r_remaining;
    logic [7:0]       r_divCnt;
    logic [WIDTH-1:0] r_count;
    logic             r_clr;
    logic [1:0]       w_grant;
    logic             w_stepDue;

    // Both requesting: the one not served last wins; otherwise the lone requester.
    always_comb begin
        w_grant = req;
        if (req == 2'b11) begin
            w_grant = r_last ? 2'b01 : 2'b10;
        end
    end

    // A due step is held off while clear is high so clear and step never coincide.
    assign w_stepDue = (r_state == c_stRun) && (r_divCnt == c_divLast) &&
                       (r_remaining != '0);
    assign step  = w_stepDue && !clear;
    assign wrap  = step && (r_count == c_countMax);
    assign gnt   = r_gnt;
    assign done  = (r_state == c_stDone) ? r_gnt : 2'b00;
    assign busy  = (r_state != c_stIdle);
    assign clr   = r_clr;
    assign count = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_stIdle;
            r_gnt       <= 2'b00;
            r_last      <= 1'b1;
            r_remaining <= '0;
            r_divCnt    <= '0;
            r_count     <= '0;
            r_clr       <= 1'b0;
        end else begin
            r_clr <= clear;
            if (clear) begin
                r_count <= '0;
            end else if (step) begin
                r_count <= wrap ? '0 : r_count + 1'b1;
            end

            case (r_state)
                c_stIdle: begin
                    if (w_grant != 2'b00) begin
                        r_state     <= c_stRun;
                        r_gnt       <= w_grant;
                        r_remaining <= w_grant[0] ? len0 : len1;
                        r_divCnt    <= '0;
                    end
                end
                c_stRun: begin
                    // DONE follows the final step directly, or at once for an empty burst.
                    if ((r_remaining == '0) || (step && (r_remaining == c_lenOne))) begin
                        r_state <= c_stDone;
                    end
                    if (step) begin
                        r_remaining <= r_remaining - 1'b1;
                        r_divCnt    <= '0;
                    end else if (r_divCnt != c_divLast) begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end
                c_stDone: begin
                    r_state <= c_stIdle;
                    r_gnt   <= 2'b00;
                    r_last  <= r_gnt[1];
                end
                default: begin
                    r_state <= c_stIdle;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_step_scheduler
// Description : Directed self-checking bench for counter_step_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_step_scheduler;

    logic       clock;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       clear;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       step;
    logic       clr;
    logic [2:0] count;
    logic       wrap;
    logic       busy;

    int nCompared;
    int nMismatched;

    // Per-cycle activity bitmaps; bit k is cycle k of the observed window.
    logic [63:0] stepM, wrapM, clrM, done0M, done1M, gnt0M, gnt1M;
    logic [2:0]  cntAt [0:63];

    counter_step_scheduler #(
        .WIDTH (3),
        .MOD_N (6),
        .LEN_W (4),
        .DIV   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .clear (clear),
        .gnt   (gnt),
        .done  (done),
        .step  (step),
        .clr   (clr),
        .count (count),
        .wrap  (wrap),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        req   = 2'b00;
        clear = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        cyc();
    endtask

    // Runs n cycles starting in the current one, modelling requesters that
    // drop req (and scramble len) once granted.
    task automatic observe(input int n, input logic [63:0] clrSched);
        stepM = '0; wrapM = '0; clrM = '0;
        done0M = '0; done1M = '0; gnt0M = '0; gnt1M = '0;
        for (int k = 1; k <= n; k++) begin
            clear = clrSched[k];
            #1;
            stepM[k]  = step;
            wrapM[k]  = wrap;
            clrM[k]   = clr;
            done0M[k] = done[0];
            done1M[k] = done[1];
            gnt0M[k]  = gnt[0];
            gnt1M[k]  = gnt[1];
            cntAt[k]  = count;
            if (gnt[0]) begin req[0] = 1'b0; len0 = 4'hF; end
            if (gnt[1]) begin req[1] = 1'b0; len1 = 4'hF; end
            cyc();
        end
        clear = 1'b0;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;
        clear = 1'b0;
        reset = 1'b0;
        #2;
        checkVal("rst_gnt",   gnt,   2'b00);
        checkVal("rst_done",  done,  2'b00);
        checkVal("rst_step",  step,  1'b0);
        checkVal("rst_clr",   clr,   1'b0);
        checkVal("rst_count", count, 3'd0);
        checkVal("rst_wrap",  wrap,  1'b0);
        checkVal("rst_busy",  busy,  1'b0);
        doReset();
        repeat (3) cyc();
        checkVal("idle_busy", busy, 1'b0);
        checkVal("idle_gnt",  gnt,  2'b00);

        // Single burst of 3 from requester 0.
        req = 2'b01; len0 = 4'd3;
        cyc();
        observe(15, 64'h0);
        checkVal("single_step",  stepM,  64'h1110);
        checkVal("single_done0", done0M, 64'h2000);
        checkVal("single_done1", done1M, 64'h0);
        checkVal("single_gnt0",  gnt0M,  64'h3FFE);
        checkVal("single_wrap",  wrapM,  64'h0);
        checkVal("single_count", count,  3'd3);

        // Round-robin with both requesting from a fresh reset.
        doReset();
        req = 2'b11; len0 = 4'd2; len1 = 4'd2;
        cyc();
        observe(22, 64'h0);
        checkVal("rr_step",  stepM,  64'h44110);
        checkVal("rr_gnt0",  gnt0M,  64'h3FE);
        checkVal("rr_gnt1",  gnt1M,  64'hFF800);
        checkVal("rr_done0", done0M, 64'h200);
        checkVal("rr_done1", done1M, 64'h80000);
        checkVal("rr_count", count,  3'd4);

        // Both re-request with zero lengths: requester 0 goes first again.
        req = 2'b11; len0 = 4'd0; len1 = 4'd0;
        cyc();
        observe(7, 64'h0);
        checkVal("rr2_gnt0",  gnt0M,  64'h6);
        checkVal("rr2_done0", done0M, 64'h4);
        checkVal("rr2_gnt1",  gnt1M,  64'h30);
        checkVal("rr2_done1", done1M, 64'h20);
        checkVal("rr2_step",  stepM,  64'h0);
        checkVal("rr2_count", count,  3'd4);

        // Wrap: 8 steps through modulus 6.
        doReset();
        req = 2'b10; len1 = 4'd8;
        cyc();
        observe(35, 64'h0);
        checkVal("wrap_step",  stepM,  64'h1_1111_1110);
        checkVal("wrap_wrap",  wrapM,  64'h100_0000);
        checkVal("wrap_done1", done1M, 64'h2_0000_0000);
        checkVal("wrap_gnt1",  gnt1M,  64'h3_FFFF_FFFE);
        checkVal("wrap_count", count,  3'd2);

        // Clear held for cycles 3..5 across the step due in cycle 4.
        req = 2'b01; len0 = 4'd2;
        cyc();
        observe(13, 64'h38);
        checkVal("clr_step",   stepM,     64'h440);
        checkVal("clr_clr",    clrM,      64'h70);
        checkVal("clr_done0",  done0M,    64'h800);
        checkVal("clr_cnt3",   cntAt[3],  3'd2);
        checkVal("clr_cnt4",   cntAt[4],  3'd0);
        checkVal("clr_cnt7",   cntAt[7],  3'd1);
        checkVal("clr_count",  count,     3'd2);

        // Zero-length burst from requester 1 alone.
        req = 2'b10; len1 = 4'd0;
        cyc();
        observe(4, 64'h0);
        checkVal("zero_gnt1",  gnt1M,  64'h6);
        checkVal("zero_done1", done1M, 64'h4);
        checkVal("zero_gnt0",  gnt0M,  64'h0);
        checkVal("zero_step",  stepM,  64'h0);
        checkVal("zero_count", count,  3'd2);

        // Asynchronous reset in the middle of a burst.
        req = 2'b01; len0 = 4'd5;
        cyc();
        req = 2'b00;
        repeat (5) cyc();
        checkVal("mid_busy",  busy,  1'b1);
        checkVal("mid_count", count, 3'd3);
        #2 reset = 1'b0;
        #1;
        checkVal("arst_gnt",   gnt,   2'b00);
        checkVal("arst_busy",  busy,  1'b0);
        checkVal("arst_count", count, 3'd0);
        checkVal("arst_step",  step,  1'b0);
        checkVal("arst_done",  done,  2'b00);
        cyc();
        reset = 1'b1;
        observe(6, 64'h0);
        checkVal("post_gnt",  gnt0M | gnt1M,   64'h0);
        checkVal("post_done", done0M | done1M, 64'h0);
        checkVal("post_busy", busy,            1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
